// File: rtl/dmem_responder.sv
// dmem_responder: sequential load/store responder over a byte-maskable word array.
// Word-crossing accesses are split into two back-to-back word accesses on a
// single memory port; load data is right-justified and sign/zero-extended.
module dmem_responder #(
    parameter int MEM_WORDS = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wren,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] LAST_BYTE = 33'(MEM_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Request decode on the live inputs, used only at the accept edge
    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic        req_err;
    logic        req_split;
    logic        req_accept;

    // Latched request fields
    logic [AW-1:0] idx_reg;
    logic [1:0]    offset_reg;
    logic [1:0]    size_reg;
    logic          signed_reg;
    logic          wren_reg;
    logic [31:0]   wdata_reg;
    logic          err_reg;
    logic          split_reg;
    logic [31:0]   lo_word_reg;

    // Memory port signals
    logic          mem_en;
    logic          mem_hi;
    logic [AW-1:0] mem_addr;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [3:0]    nmask;
    logic [7:0]    be8;
    logic [63:0]   wr64;
    logic [63:0]   rd64;
    logic [31:0]   raw;
    logic [31:0]   load_data;

    // Byte count, 33-bit end address (no wrap), error and split detection
    always_comb begin
        case (i_req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_last   = {1'b0, i_req_addr} + {30'b0, req_nbytes} - 33'd1;
        req_err    = (i_req_size == 2'b11) || (req_last > LAST_BYTE);
        req_split  = ({2'b00, i_req_addr[1:0]} + {1'b0, req_nbytes}) > 4'd4;
        req_accept = i_req_valid && (state_reg == IDLE);
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // FSM next state and handshake/response outputs
    always_comb begin
        state_next  = state_reg;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = 32'h0;
        o_rsp_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_next = req_err ? RESP : ACC0;
            end
            ACC0: state_next = split_reg ? ACC1 : RESP;
            ACC1: state_next = RESP;
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_reg;
                o_rsp_rdata = (err_reg || wren_reg) ? 32'h0 : load_data;
                if (i_rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture request fields at accept; keep first read word across ACC1
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx_reg     <= '0;
            offset_reg  <= 2'b00;
            size_reg    <= 2'b00;
            signed_reg  <= 1'b0;
            wren_reg    <= 1'b0;
            wdata_reg   <= 32'h0;
            err_reg     <= 1'b0;
            split_reg   <= 1'b0;
            lo_word_reg <= 32'h0;
        end else begin
            if (req_accept) begin
                idx_reg    <= i_req_addr[AW+1:2];
                offset_reg <= i_req_addr[1:0];
                size_reg   <= i_req_size;
                signed_reg <= i_req_signed;
                wren_reg   <= i_req_wren;
                wdata_reg  <= i_req_wdata;
                err_reg    <= req_err;
                split_reg  <= req_split;
            end
            if (state_reg == ACC1) lo_word_reg <= rd_word;
        end
    end

    // Store alignment: data and lane mask spread over a two-word window
    always_comb begin
        case (size_reg)
            2'b00:   nmask = 4'b0001;
            2'b01:   nmask = 4'b0011;
            default: nmask = 4'b1111;
        endcase
        be8        = {4'b0000, nmask} << offset_reg;
        wr64       = {32'h0, wdata_reg} << {offset_reg, 3'b000};
        mem_en     = (state_reg == ACC0) || (state_reg == ACC1);
        mem_hi     = (state_reg == ACC1);
        mem_addr   = mem_hi ? (idx_reg + AW'(1)) : idx_reg;
        lane_we    = (mem_en && wren_reg) ? (mem_hi ? be8[7:4] : be8[3:0]) : 4'b0000;
        lane_wdata = mem_hi ? wr64[63:32] : wr64[31:0];
    end

    // One byte-wide RAM per lane, registered read, write-enabled per lane
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_q;

            // Single-port lane RAM: read-before-write on each access cycle
            always_ff @(posedge i_clk) begin
                if (mem_en) begin
                    if (lane_we[gi]) lane_mem[mem_addr] <= lane_wdata[gi*8 +: 8];
                    lane_q <= lane_mem[mem_addr];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_q;
        end
    endgenerate

    // Load assembly: address-ordered bytes, right-justified, then extended
    always_comb begin
        rd64 = split_reg ? {rd_word, lo_word_reg} : {32'h0, rd_word};
        raw  = 32'(rd64 >> {offset_reg, 3'b000});
        case (size_reg)
            2'b00:   load_data = {{24{signed_reg & raw[7]}},  raw[7:0]};
            2'b01:   load_data = {{16{signed_reg & raw[15]}}, raw[15:0]};
            default: load_data = raw;
        endcase
    end

endmodule
